if_fetch: RTL and testbench

- Instruction-fetch stage, directly upstream of the IF/ID pipeline register.
- Owns the PC and runs a single-outstanding bus-master handshake to instruction memory.
- Presents a fetched pc/instruction pair to IF/ID, and raises a stall request to the pipeline controller while a fetch is pending.
- Handles branch redirect, exception flush and pipeline stall, including a flush that arrives while a bus access is outstanding.

---
 rtl/if_fetch_pkg.sv | 9 +
 rtl/if_fetch.sv | 74 +++++++
 tb/tb_if_fetch.sv | 101 ++++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared fetch-stage widths, constants and state encoding
package if_fetch_pkg;
  localparam int INST_ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int STALL_W = 6;
  localparam logic [INST_W-1:0] ZERO_WORD = '0;
  localparam logic STOP = 1'b1;
  typedef enum logic [1:0] {ST_START, ST_REQ, ST_HOLD, ST_DRAIN} fetch_state_e;
endpackage

// File: rtl/if_fetch.sv
// if_fetch: PC owner and single-outstanding instruction bus master feeding IF/ID
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [INST_ADDR_W-1:0] PC_STEP = 32'd4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_W-1:0]     stall,
  input  logic                   flush,
  input  logic [INST_ADDR_W-1:0] new_pc,
  input  logic                   branch_flag_i,
  input  logic [INST_ADDR_W-1:0] branch_target_i,
  output logic                   bus_req_o,
  output logic [INST_ADDR_W-1:0] bus_addr_o,
  input  logic                   bus_ack_i,
  input  logic [INST_W-1:0]      bus_data_i,
  output logic                   ce_o,
  output logic [INST_ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0]      if_inst,
  output logic                   stallreq_o
);
  fetch_state_e r_state, w_next;
  logic [INST_ADDR_W-1:0] r_pc, r_addr, w_addr, w_next_pc;
  logic [INST_W-1:0] r_buf;
  logic w_stop, w_adv, w_unused;
  assign w_unused = ^stall[STALL_W-1:1];
  assign w_stop = stall[0] == STOP;
  assign w_next_pc = branch_flag_i ? branch_target_i : r_pc + PC_STEP;
  assign w_adv = !flush && !w_stop && ((r_state == ST_REQ && bus_ack_i) || r_state == ST_HOLD);
  always_ff @(posedge clk)
    r_state <= rst ? ST_START : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_START: w_next = ST_REQ;
      ST_REQ:   w_next = flush ? (bus_ack_i ? ST_REQ : ST_DRAIN) : (bus_ack_i && w_stop) ? ST_HOLD : ST_REQ;
      ST_HOLD:  w_next = (flush || !w_stop) ? ST_REQ : ST_HOLD;
      ST_DRAIN: w_next = bus_ack_i ? ST_REQ : ST_DRAIN;
      default:  w_next = ST_START;
    endcase
  end
  // An access completing in DRAIN frees the bus, so a flush landing on that same edge goes straight to REQ.
  always_comb begin
    w_addr = r_addr;
    if (r_state == ST_START || (r_state == ST_DRAIN && bus_ack_i))
      w_addr = flush ? new_pc : r_pc;
    else if (flush && (r_state == ST_HOLD || bus_ack_i))
      w_addr = new_pc;
    else if (w_adv)
      w_addr = w_next_pc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc   <= RESET_PC;
      r_addr <= RESET_PC;
      r_buf  <= ZERO_WORD;
    end else begin
      r_addr <= w_addr;
      r_pc   <= flush ? new_pc : w_adv ? w_next_pc : r_pc;
      r_buf  <= flush ? ZERO_WORD : (r_state == ST_REQ && bus_ack_i && w_stop) ? bus_data_i : r_buf;
    end
  end
  always_comb begin
    bus_req_o  = r_state == ST_REQ || r_state == ST_DRAIN;
    stallreq_o = r_state == ST_DRAIN || (r_state == ST_REQ && !bus_ack_i);
    ce_o       = r_state != ST_START;
    if_inst    = (r_state == ST_REQ && bus_ack_i && !w_stop && !flush) ? bus_data_i :
                 r_state == ST_HOLD ? r_buf : ZERO_WORD;
  end
  assign bus_addr_o = r_addr;
  assign if_pc = r_pc;
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed per-cycle vectors with queued expectations checked by a monitor
module tb_if_fetch;
  logic clk = 0, rst = 1, flush = 0, branch_flag_i = 0, bus_ack_i = 0;
  logic [5:0] stall = 0;
  logic [31:0] new_pc = 0, branch_target_i = 0, bus_data_i = 0;
  logic bus_req_o, ce_o, stallreq_o;
  logic [31:0] bus_addr_o, if_pc, if_inst;
  typedef struct packed {
    logic req; logic [31:0] addr; logic [31:0] pc; logic [31:0] inst; logic sreq; logic ce;
  } exp_t;
  exp_t q[$];
  int total = 0, bad = 0, row = 0, mrow = 0;
  if_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o), .bus_ack_i(bus_ack_i),
    .bus_data_i(bus_data_i), .ce_o(ce_o), .if_pc(if_pc), .if_inst(if_inst),
    .stallreq_o(stallreq_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL row %0d %s: got %h expected %h", mrow, name, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("bus_req_o", {31'b0, bus_req_o}, {31'b0, e.req});
      chk("bus_addr_o", bus_addr_o, e.addr);
      chk("if_pc", if_pc, e.pc);
      chk("if_inst", if_inst, e.inst);
      chk("stallreq_o", {31'b0, stallreq_o}, {31'b0, e.sreq});
      chk("ce_o", {31'b0, ce_o}, {31'b0, e.ce});
      mrow++;
    end
  end
  task automatic cyc(input logic r, input logic st, input logic fl, input logic [31:0] npc,
                     input logic br, input logic [31:0] tgt, input logic ack, input logic [31:0] d,
                     input logic e_req, input logic [31:0] e_addr, input logic [31:0] e_pc,
                     input logic [31:0] e_inst, input logic e_sreq, input logic e_ce);
    @(posedge clk);
    #1;
    rst = r; stall = {5'b10101, st}; flush = fl; new_pc = npc;
    branch_flag_i = br; branch_target_i = tgt; bus_ack_i = ack; bus_data_i = d;
    q.push_back('{e_req, e_addr, e_pc, e_inst, e_sreq, e_ce});
    row++;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    //  rst st fl new_pc  br target ack data          req addr          pc            inst          sreq ce
    cyc(1, 0, 0, 32'h0,   0, 32'h0, 0, 32'h0,         0, 32'h0,         32'h0,        32'h0,        0, 0);
    cyc(0, 0, 0, 32'h0,   0, 32'h0, 0, 32'h0,         0, 32'h0,         32'h0,        32'h0,        0, 0);
    cyc(0, 0, 0, 32'h0,   0, 32'h0, 1, 32'hA0,        1, 32'h0,         32'h0,        32'hA0,       0, 1);
    cyc(0, 0, 0, 32'h0,   0, 32'h0, 1, 32'hA1,        1, 32'h4,         32'h4,        32'hA1,       0, 1);
    cyc(0, 0, 0, 32'h0,   0, 32'h0, 0, 32'h0,         1, 32'h8,         32'h8,        32'h0,        1, 1);
    cyc(0, 0, 0, 32'h0,   0, 32'h0, 0, 32'h0,         1, 32'h8,         32'h8,        32'h0,        1, 1);
    cyc(0, 0, 0, 32'h0,   0, 32'h0, 0, 32'h0,         1, 32'h8,         32'h8,        32'h0,        1, 1);
    cyc(0, 0, 0, 32'h0,   0, 32'h0, 1, 32'hA2,        1, 32'h8,         32'h8,        32'hA2,       0, 1);
    cyc(0, 1, 0, 32'h0,   0, 32'h0, 1, 32'hA3,        1, 32'hC,         32'hC,        32'h0,        0, 1);
    cyc(0, 1, 0, 32'h0,   0, 32'h0, 0, 32'h0,         0, 32'hC,         32'hC,        32'hA3,       0, 1);
    cyc(0, 0, 0, 32'h0,   0, 32'h0, 0, 32'h0,         0, 32'hC,         32'hC,        32'hA3,       0, 1);
    cyc(0, 0, 0, 32'h0,   0, 32'h0, 1, 32'hA4,        1, 32'h10,        32'h10,       32'hA4,       0, 1);
    cyc(0, 0, 0, 32'h0,   0, 32'h0, 1, 32'hA5,        1, 32'h14,        32'h14,       32'hA5,       0, 1);
    cyc(0, 0, 0, 32'h0,   0, 32'h0, 1, 32'hA6,        1, 32'h18,        32'h18,       32'hA6,       0, 1);
    cyc(0, 0, 0, 32'h0,   0, 32'h0, 1, 32'hA7,        1, 32'h1C,        32'h1C,       32'hA7,       0, 1);
    cyc(0, 0, 0, 32'h0,   1, 32'h100, 1, 32'hA8,      1, 32'h20,        32'h20,       32'hA8,       0, 1);
    cyc(0, 0, 0, 32'h0,   0, 32'h0, 0, 32'h0,         1, 32'h100,       32'h100,      32'h0,        1, 1);
    cyc(0, 0, 1, 32'h180, 0, 32'h0, 0, 32'h0,         1, 32'h100,       32'h100,      32'h0,        1, 1);
    cyc(0, 0, 0, 32'h0,   0, 32'h0, 0, 32'h0,         1, 32'h100,       32'h180,      32'h0,        1, 1);
    cyc(0, 0, 0, 32'h0,   0, 32'h0, 1, 32'hDEAD,      1, 32'h100,       32'h180,      32'h0,        1, 1);
    cyc(0, 0, 0, 32'h0,   0, 32'h0, 1, 32'hB0,        1, 32'h180,       32'h180,      32'hB0,       0, 1);
    cyc(0, 0, 0, 32'h0,   0, 32'h0, 0, 32'h0,         1, 32'h184,       32'h184,      32'h0,        1, 1);
    cyc(1, 0, 0, 32'h0,   0, 32'h0, 0, 32'h0,         1, 32'h184,       32'h184,      32'h0,        1, 1);
    cyc(0, 0, 0, 32'h0,   0, 32'h0, 1, 32'hDEAD,      0, 32'h0,         32'h0,        32'h0,        0, 0);
    cyc(0, 0, 0, 32'h0,   0, 32'h0, 0, 32'h0,         1, 32'h0,         32'h0,        32'h0,        1, 1);
    cyc(0, 0, 1, 32'h200, 0, 32'h0, 1, 32'hDEAD,      1, 32'h0,         32'h0,        32'h0,        0, 1);
    cyc(0, 0, 0, 32'h0,   0, 32'h0, 1, 32'hC0,        1, 32'h200,       32'h200,      32'hC0,       0, 1);
    cyc(0, 1, 0, 32'h0,   0, 32'h0, 1, 32'hC1,        1, 32'h204,       32'h204,      32'h0,        0, 1);
    cyc(0, 1, 1, 32'h300, 0, 32'h0, 0, 32'h0,         0, 32'h204,       32'h204,      32'hC1,       0, 1);
    cyc(0, 0, 0, 32'h0,   0, 32'h0, 0, 32'h0,         1, 32'h300,       32'h300,      32'h0,        1, 1);
    cyc(0, 0, 1, 32'h400, 0, 32'h0, 0, 32'h0,         1, 32'h300,       32'h300,      32'h0,        1, 1);
    cyc(0, 0, 1, 32'h500, 0, 32'h0, 0, 32'h0,         1, 32'h300,       32'h400,      32'h0,        1, 1);
    cyc(0, 0, 0, 32'h0,   0, 32'h0, 1, 32'hDEAD,      1, 32'h300,       32'h500,      32'h0,        1, 1);
    cyc(0, 0, 0, 32'h0,   0, 32'h0, 1, 32'hD0,        1, 32'h500,       32'h500,      32'hD0,       0, 1);
    cyc(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'hDEAD, 1, 32'h504,      32'h504,      32'h0,        0, 1);
    cyc(0, 0, 0, 32'h0,   0, 32'h0, 1, 32'hE0,        1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hE0,      0, 1);
    cyc(0, 0, 0, 32'h0,   0, 32'h0, 0, 32'h0,         1, 32'h0,         32'h0,        32'h0,        1, 1);
    cyc(1, 0, 0, 32'h0,   0, 32'h0, 0, 32'h0,         1, 32'h0,         32'h0,        32'h0,        1, 1);
    cyc(0, 0, 1, 32'h600, 0, 32'h0, 0, 32'h0,         0, 32'h0,         32'h0,        32'h0,        0, 0);
    cyc(0, 0, 0, 32'h0,   0, 32'h0, 0, 32'h0,         1, 32'h600,       32'h600,      32'h0,        1, 1);
    repeat (2) @(negedge clk);
    chk("scoreboard drained", q.size(), 0);
    chk("rows checked", mrow, row);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
